// File: rtl/inputconditioner_multi.sv
// Multi-channel input conditioner.
// Each channel synchronises a raw asynchronous input through a flop chain,
// debounces it against a shared run-time wait time, and produces one-cycle
// rising/falling edge pulses plus a sticky edge flag with a clear input.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   noisysignal  raw asynchronous inputs, bit i = channel i
//   wait_time    debounce threshold W, shared by all channels, quasi-static
//   flag_clear   per-channel clear of edge_flags, level-sampled each clk
//   conditioned  synchronised, debounced level per channel
//   positiveedge one-cycle pulse when conditioned[i] goes 0->1
//   negativeedge one-cycle pulse when conditioned[i] goes 1->0
//   any_edge     high in the cycles where any edge pulse is high
//   edge_flags   sticky per-channel edge indication, held until cleared
module inputconditioner_multi #(
  parameter int unsigned       NUM_CH       = 4,
  parameter int unsigned       SYNC_STAGES  = 2,
  parameter int unsigned       COUNTERWIDTH = 3,
  parameter logic [NUM_CH-1:0] RESET_VAL    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       noisysignal,
  input  logic [COUNTERWIDTH-1:0] wait_time,
  input  logic [NUM_CH-1:0]       flag_clear,
  output logic [NUM_CH-1:0]       conditioned,
  output logic [NUM_CH-1:0]       positiveedge,
  output logic [NUM_CH-1:0]       negativeedge,
  output logic                    any_edge,
  output logic [NUM_CH-1:0]       edge_flags
);

  // Stage 0 takes the raw pin; stage SYNC_STAGES-1 is the synchronised sample.
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q, sync_d;
  logic [NUM_CH-1:0][COUNTERWIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0]                   cond_q, cond_d;
  logic [NUM_CH-1:0]                   pos_q, pos_d;
  logic [NUM_CH-1:0]                   neg_q, neg_d;
  logic [NUM_CH-1:0]                   flags_q, flags_d;
  logic                                any_q, any_d;
  logic [NUM_CH-1:0]                   sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], noisysignal};

  always_comb begin
    cnt_d  = cnt_q;
    cond_d = cond_q;
    pos_d  = '0;
    neg_d  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (sync_s[i] == cond_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= wait_time) begin
        // Disagreement has persisted for W+1 edges: accept the new level.
        // The >= also covers wait_time being lowered below the running count.
        cnt_d[i]  = '0;
        cond_d[i] = sync_s[i];
        pos_d[i]  = sync_s[i];
        neg_d[i]  = ~sync_s[i];
      end else begin
        // Cannot wrap: we only get here while cnt_q < wait_time.
        cnt_d[i] = cnt_q[i] + COUNTERWIDTH'(1);
      end
    end
    // A new edge wins over a simultaneous clear.
    flags_d = (flags_q & ~flag_clear) | pos_d | neg_d;
    any_d   = |(pos_d | neg_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= '0;
      cond_q  <= RESET_VAL;
      pos_q   <= '0;
      neg_q   <= '0;
      flags_q <= '0;
      any_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      cond_q  <= cond_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      flags_q <= flags_d;
      any_q   <= any_d;
    end
  end

  assign conditioned  = cond_q;
  assign positiveedge = pos_q;
  assign negativeedge = neg_q;
  assign any_edge     = any_q;
  assign edge_flags   = flags_q;

endmodule

// File: tb/tb_inputconditioner_multi.sv
// Self-checking bench for inputconditioner_multi (default parameters).
module tb_inputconditioner_multi;

  logic       clk;
  logic       rst_n;
  logic [3:0] noisysignal;
  logic [2:0] wait_time;
  logic [3:0] flag_clear;
  logic [3:0] conditioned;
  logic [3:0] positiveedge;
  logic [3:0] negativeedge;
  logic       any_edge;
  logic [3:0] edge_flags;

  int checks   = 0;
  int failures = 0;

  inputconditioner_multi dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .noisysignal  (noisysignal),
    .wait_time    (wait_time),
    .flag_clear   (flag_clear),
    .conditioned  (conditioned),
    .positiveedge (positiveedge),
    .negativeedge (negativeedge),
    .any_edge     (any_edge),
    .edge_flags   (edge_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] noisy;
    logic [2:0] wt;
    logic [3:0] clr;
    logic [3:0] cond;
    logic [3:0] pos;
    logic [3:0] neg;
    logic       any;
    logic [3:0] flags;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] n, input logic [2:0] w, input logic [3:0] c,
                     input logic [3:0] ec, input logic [3:0] ep, input logic [3:0] en,
                     input logic ea, input logic [3:0] ef);
    vec_t v;
    v.noisy = n; v.wt = w; v.clr = c;
    v.cond = ec; v.pos = ep; v.neg = en; v.any = ea; v.flags = ef;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock edge and sample shortly after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ec, input logic [3:0] ep,
                         input logic [3:0] en, input logic ea, input logic [3:0] ef);
    chk({tag, " cond"}, 32'(conditioned), 32'(ec));
    chk({tag, " pos"}, 32'(positiveedge), 32'(ep));
    chk({tag, " neg"}, 32'(negativeedge), 32'(en));
    chk({tag, " any"}, 32'(any_edge), 32'(ea));
    chk({tag, " flags"}, 32'(edge_flags), 32'(ef));
  endtask

  initial begin
    int rise, fall, highs, pulses;

    // Clean rise on ch0, W=3: change lands on the 6th edge.
    repeat (5) add(4'h1, 3'd3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    add(4'h1, 3'd3, 4'h0, 4'h1, 4'h1, 4'h0, 1'b1, 4'h1);
    add(4'h1, 3'd3, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1);
    // ch1 high for 3 clocks: rejected.
    repeat (3) add(4'h3, 3'd3, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1);
    repeat (4) add(4'h1, 3'd3, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1);
    // ch1 high for 4 clocks: accepted, then falls.
    repeat (4) add(4'h3, 3'd3, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1);
    add(4'h1, 3'd3, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h1);
    add(4'h1, 3'd3, 4'h0, 4'h3, 4'h2, 4'h0, 1'b1, 4'h3);
    repeat (3) add(4'h1, 3'd3, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0, 4'h3);
    add(4'h1, 3'd3, 4'h0, 4'h1, 4'h0, 4'h2, 1'b1, 4'h3);
    add(4'h1, 3'd3, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 4'h3);

    // Reset held with inputs high: everything stays at reset values.
    rst_n = 1'b0; noisysignal = 4'hF; wait_time = 3'd3; flag_clear = 4'h0;
    repeat (3) step();
    chk_all("in_reset", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    noisysignal = 4'h0;
    #3 rst_n = 1'b1;
    repeat (2) step();
    chk_all("after_reset", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);

    foreach (vecs[i]) begin
      noisysignal = vecs[i].noisy;
      wait_time   = vecs[i].wt;
      flag_clear  = vecs[i].clr;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].cond, vecs[i].pos, vecs[i].neg,
              vecs[i].any, vecs[i].flags);
    end

    // Asynchronous reset pulse between edges clears state immediately.
    #3 rst_n = 1'b0;
    #1 chk_all("async_reset", 4'h0, 4'h0, 4'h0, 1'b0, 4'h0);
    noisysignal = 4'h0;
    #2 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      pulses += int'(any_edge);
    end
    chk("no_pulse_after_reset", 32'(pulses), 32'd0);
    chk("cond_after_reset", 32'(conditioned), 32'h0);

    // W=0: a one-clock pulse on ch3 is accepted on edge 3, and falls on edge 4.
    wait_time = 3'd0; noisysignal = 4'h8;
    step();
    noisysignal = 4'h0;
    step();
    chk("w0 e2 cond", 32'(conditioned), 32'h0);
    step();
    chk_all("w0 e3", 4'h8, 4'h8, 4'h0, 1'b1, 4'h8);
    step();
    chk_all("w0 e4", 4'h0, 4'h0, 4'h8, 1'b1, 4'h8);
    repeat (2) step();

    // W=7: a 7-cycle pulse is rejected.
    wait_time = 3'd7; highs = 0;
    for (int i = 1; i <= 16; i++) begin
      noisysignal = (i <= 7) ? 4'h8 : 4'h0;
      step();
      highs += int'(conditioned[3]) + int'(positiveedge[3]);
    end
    chk("w7 reject", 32'(highs), 32'd0);

    // W=7: an 8-cycle pulse rises on edge 10 and falls on edge 18.
    rise = 0; fall = 0;
    for (int i = 1; i <= 24; i++) begin
      noisysignal = (i <= 8) ? 4'h8 : 4'h0;
      step();
      if (conditioned[3] && rise == 0) rise = i;
      if (!conditioned[3] && rise != 0 && fall == 0) fall = i;
    end
    chk("w7 rise edge", 32'(rise), 32'd10);
    chk("w7 fall edge", 32'(fall), 32'd18);

    // Clear all flags.
    flag_clear = 4'hF;
    step();
    flag_clear = 4'h0;
    chk("clear_all flags", 32'(edge_flags), 32'h0);

    // Lowering wait_time below the running count accepts on the next edge.
    wait_time = 3'd7; noisysignal = 4'h4;
    repeat (6) step();
    chk("wchg e6 cond", 32'(conditioned), 32'h0);
    wait_time = 3'd2;
    step();
    chk_all("wchg e7", 4'h4, 4'h4, 4'h0, 1'b1, 4'h4);

    // Flag clear handshake on ch2.
    flag_clear = 4'h4;
    step();
    flag_clear = 4'h0;
    chk("flag cleared", 32'(edge_flags), 32'h0);

    // Clear coinciding with a new ch2 edge: set wins.
    wait_time = 3'd0; noisysignal = 4'h0;
    repeat (2) step();
    chk("set_wins e2 neg", 32'(negativeedge), 32'h0);
    flag_clear = 4'h4;
    step();
    chk("set_wins e3 neg", 32'(negativeedge), 32'h4);
    chk("set_wins e3 flags", 32'(edge_flags), 32'h4);
    flag_clear = 4'h0;
    step();
    chk("set_wins held", 32'(edge_flags), 32'h4);

    // All four channels rise together.
    flag_clear = 4'hF;
    step();
    flag_clear = 4'h0;
    wait_time = 3'd3; noisysignal = 4'hF;
    repeat (5) step();
    chk("simul e5 pos", 32'(positiveedge), 32'h0);
    step();
    chk_all("simul e6", 4'hF, 4'hF, 4'h0, 1'b1, 4'hF);
    step();
    chk_all("simul e7", 4'hF, 4'h0, 4'h0, 1'b0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inputconditioner_multi.md
Name: inputconditioner_multi

Overview:
Parametrised, multi-channel successor to the single-bit input conditioner. Each of NUM_CH raw inputs (buttons, switches, external pins) is synchronised through a configurable-depth flop chain and debounced by a per-channel counter against a run-time wait time. Each channel also gets one-cycle rising and falling edge pulses. Sticky per-channel edge flags with a clear handshake let slow consumers (FSM or CPU poll) catch events. Sits between top-level pins and all downstream control logic.

Parameters:
NUM_CH, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
COUNTERWIDTH, 3, width of per-channel debounce counter and of wait_time
RESET_VAL, {NUM_CH{1'b0}}, per-channel reset value of synchroniser chain and conditioned output

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
noisysignal  input  NUM_CH  raw asynchronous inputs, bit i = channel i
wait_time  input  COUNTERWIDTH  debounce threshold W, quasi-static, shared by all channels
flag_clear  input  NUM_CH  per-channel clear of edge_flags, level-sampled each clk
conditioned  output  NUM_CH  synchronised, debounced level
positiveedge  output  NUM_CH  one-cycle pulse when conditioned[i] goes 0->1
negativeedge  output  NUM_CH  one-cycle pulse when conditioned[i] goes 1->0
any_edge  output  1  registered OR of all positiveedge|negativeedge bits, same cycle as the pulses
edge_flags  output  NUM_CH  sticky: set by any edge on channel i, held until cleared

Behaviour:
- Reset: rst_n low asynchronously forces:
  - sync chain and conditioned to RESET_VAL
  - counters to 0
  - positiveedge, negativeedge, any_edge, edge_flags to 0
- Reset release mid-bounce: filtering restarts from the reset state; no edge pulse results from the reset itself.
- All outputs are registered. No combinational path from any input to any output.
- Per channel i, each clk:
  - sync chain shifts: stage0 <= noisysignal[i]; s = last stage.
  - If s == conditioned[i]: counter <= 0; no pulse.
  - Else if counter >= W: counter <= 0; conditioned[i] <= s; positiveedge[i] <= s; negativeedge[i] <= ~s.
  - Else: counter <= counter + 1; no pulse.
- Pulses are high for exactly one cycle. They coincide with the cycle in which conditioned changes.
- Acceptance rule: s must differ from conditioned on W+1 consecutive clk edges. Any shorter excursion is rejected; the counter restarts from 0 on the next disagreement.
- Latency: input stable before clk edge 1 gives conditioned changed after edge SYNC_STAGES+W+1 (defaults, W=3: edge 6).
- W=0: any disagreement is accepted on the first evaluating edge (synchroniser-only latency, SYNC_STAGES+1).
- The counter never wraps: max reachable value is W, and W <= 2^COUNTERWIDTH-1.
- Changing wait_time mid-count uses the >= compare. If the new W is <= counter, acceptance occurs on the next disagreeing edge.
- Channels are fully independent. Simultaneous edges on several channels are all reported in the same cycle.
- edge_flags[i] next value = (edge_flags[i] & ~flag_clear[i]) | positiveedge_next[i] | negativeedge_next[i].
  - Set wins over a simultaneous clear.
  - Clear takes effect the edge after flag_clear is sampled high.
- any_edge is high exactly in the cycles where at least one positiveedge/negativeedge bit is high.

Test Plan:
- Reset: drive noisysignal=4'hF, wait_time=3, pulse rst_n low between edges -> all outputs 0 immediately (async); conditioned=0 while rst_n low.
- Clean rise, ch0: 0->1 held, defaults, W=3 -> conditioned[0]=1 and positiveedge[0]=1 after edge 6 only; any_edge=1 same cycle; edge_flags[0]=1 from then on; other channels unchanged.
- Glitch reject: ch1 high for 3 clk then low, W=3 -> conditioned[1] stays 0; no pulses. Repeat with 4 clk high -> accepted, then negativeedge[1] pulse after the fall.
- W=0 and W=7: one-cycle-wide input held 1 clk with W=0 -> accepted after edge 3. With W=7, a 7-cycle pulse is rejected and an 8-cycle pulse is accepted.
- Flag handshake: edge_flags[2]=1, assert flag_clear[2] one cycle -> flag 0 next edge. Assert flag_clear[2] on the same edge as a new ch2 edge -> flag stays 1.
- Simultaneous: all 4 channels rise together -> positiveedge=4'hF for one cycle, any_edge=1 for that single cycle, edge_flags=4'hF.
